// File: rtl/lock_ctrl_if.sv
// Keypad-event and display-select bundle between the keypad/debounce stage,
// the lock controller and the VGA display stage.
interface lock_ctrl_if;
  // key_valid is a one-cycle strobe with key_code valid in the same cycle; there is
  // no ready: the controller samples every strobe and silently drops keys it ignores.
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] state_ctrl;
  logic       right_flag;
  logic       changed_flag;
  logic       unlock;
  logic [3:0] fail_cnt;

  modport master (
    output key_valid, key_code,
    input  state_ctrl, right_flag, changed_flag, unlock, fail_cnt
  );

  modport slave (
    input  key_valid, key_code,
    output state_ctrl, right_flag, changed_flag, unlock, fail_cnt
  );
endinterface

// File: rtl/lock_ctrl.sv
// Password state machine for the digital lock: 4-digit BCD entry, compare,
// password change, failed-attempt counting and timed lockout.
module lock_ctrl #(
  parameter logic [15:0] DEFAULT_PWD = 16'h1234,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 1_000_000_000
) (
  input  logic        clk,
  input  logic        rst,
  lock_ctrl_if.slave  bus
);
  typedef enum logic [3:0] {
    SYS_INIT = 4'd0,
    INPUT_0  = 4'd1,
    INPUT_1  = 4'd2,
    INPUT_2  = 4'd3,
    INPUT_3  = 4'd4,
    PWD_JUG  = 4'd5,
    PWD_CHS  = 4'd6,
    PWD_RES  = 4'd7,
    SYS_LOCK = 4'd8
  } state_t;

  localparam logic [3:0]  KEY_ENTER  = 4'hA;
  localparam logic [3:0]  KEY_CHANGE = 4'hB;
  localparam logic [3:0]  KEY_CLEAR  = 4'hC;
  localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES - 1);
  localparam logic [3:0]  FAIL_LIMIT = 4'(MAX_FAIL);

  state_t      state;
  logic [15:0] pwd;
  logic [15:0] entry_buf;
  logic [15:0] new_buf;
  logic [2:0]  new_cnt;
  logic [31:0] lock_timer;
  logic        right_q;
  logic        changed_q;
  logic        unlock_q;
  logic [3:0]  fail_q;
  logic        is_digit;

  assign is_digit = (bus.key_code <= 4'd9);

  // Entry digit count is carried by INPUT_0..INPUT_3 itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SYS_INIT;
      pwd        <= DEFAULT_PWD;
      entry_buf  <= '0;
      new_buf    <= '0;
      new_cnt    <= '0;
      lock_timer <= '0;
      right_q    <= 1'b0;
      changed_q  <= 1'b0;
      unlock_q   <= 1'b0;
      fail_q     <= '0;
    end else begin
      case (state)
        SYS_INIT: begin
          if (bus.key_valid && is_digit) begin
            entry_buf <= {entry_buf[11:0], bus.key_code};
            state     <= INPUT_0;
          end
        end
        INPUT_0, INPUT_1, INPUT_2, INPUT_3: begin
          if (bus.key_valid) begin
            if (is_digit && state != INPUT_3) begin
              entry_buf <= {entry_buf[11:0], bus.key_code};
              state     <= state_t'(state + 4'd1);
            end else if (bus.key_code == KEY_ENTER && state == INPUT_3) begin
              state    <= PWD_JUG;
              right_q  <= (entry_buf == pwd);
              unlock_q <= (entry_buf == pwd);
              if (entry_buf == pwd) fail_q <= '0;
              else if (fail_q != 4'hF) fail_q <= fail_q + 4'd1;
            end else if (bus.key_code == KEY_CLEAR) begin
              state     <= SYS_INIT;
              entry_buf <= '0;
            end
          end
        end
        PWD_JUG: begin
          if (bus.key_valid) begin
            right_q   <= 1'b0;
            unlock_q  <= 1'b0;
            entry_buf <= '0;
            if (right_q && bus.key_code == KEY_CHANGE) begin
              state   <= PWD_CHS;
              new_buf <= '0;
              new_cnt <= '0;
            end else if (!right_q && fail_q >= FAIL_LIMIT) begin
              state      <= SYS_LOCK;
              lock_timer <= LOCK_LOAD;
            end else begin
              state <= SYS_INIT;
            end
          end
        end
        PWD_CHS: begin
          if (bus.key_valid) begin
            if (is_digit && new_cnt != 3'd4) begin
              new_buf <= {new_buf[11:0], bus.key_code};
              new_cnt <= new_cnt + 3'd1;
            end else if (bus.key_code == KEY_ENTER && new_cnt == 3'd4) begin
              pwd       <= new_buf;
              changed_q <= 1'b1;
              state     <= PWD_RES;
            end else if (bus.key_code == KEY_CLEAR) begin
              state     <= SYS_INIT;
              new_buf   <= '0;
              new_cnt   <= '0;
              entry_buf <= '0;
            end
          end
        end
        PWD_RES: begin
          if (bus.key_valid) begin
            changed_q <= 1'b0;
            entry_buf <= '0;
            state     <= SYS_INIT;
          end
        end
        SYS_LOCK: begin
          // Keys are never looked at here, including one arriving on the expiry edge.
          if (lock_timer == 32'd0) begin
            state     <= SYS_INIT;
            fail_q    <= '0;
            entry_buf <= '0;
          end else begin
            lock_timer <= lock_timer - 32'd1;
          end
        end
        default: begin
          state     <= SYS_INIT;
          entry_buf <= '0;
        end
      endcase
    end
  end

  assign bus.state_ctrl   = state;
  assign bus.right_flag   = right_q;
  assign bus.changed_flag = changed_q;
  assign bus.unlock       = unlock_q;
  assign bus.fail_cnt     = fail_q;
endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random keys, all checked
// against a digit-queue model of the lock's user-visible behaviour.
module tb_lock_ctrl;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 20;
  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_CHANGE = 4'hB;
  localparam logic [3:0] K_CLEAR  = 4'hC;
  localparam int M_ENTRY = 0, M_JUDGED = 1, M_CHANGING = 2, M_CHANGED = 3, M_LOCKED = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lock_ctrl_if bus();

  lock_ctrl #(
    .DEFAULT_PWD (16'h1234),
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];

  // ---------------- reference model ----------------
  int          mode;
  int          digits[$];
  int          newd[$];
  logic [15:0] m_pwd;
  bit          m_right;
  int          m_fail;
  int          lock_left;

  function automatic logic [15:0] pack(input int q[$]);
    logic [15:0] v;
    v = '0;
    foreach (q[i]) v = {v[11:0], 4'(q[i])};
    return v;
  endfunction

  function automatic void model_reset();
    mode = M_ENTRY;
    digits.delete();
    newd.delete();
    m_pwd     = 16'h1234;
    m_right   = 1'b0;
    m_fail    = 0;
    lock_left = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [3:0] c);
    bit dig;
    dig = (c <= 4'd9);
    if (mode == M_LOCKED) begin
      if (lock_left == 0) begin
        mode = M_ENTRY;
        digits.delete();
        m_fail = 0;
      end else lock_left--;
    end else if (v) begin
      case (mode)
        M_ENTRY: begin
          if (dig && digits.size() < 4) digits.push_back(int'(c));
          else if (c == K_ENTER && digits.size() == 4) begin
            m_right = (pack(digits) == m_pwd);
            if (m_right) m_fail = 0;
            else if (m_fail < 15) m_fail++;
            mode = M_JUDGED;
          end else if (c == K_CLEAR) digits.delete();
        end
        M_JUDGED: begin
          if (m_right && c == K_CHANGE) begin
            mode = M_CHANGING;
            newd.delete();
          end else if (!m_right && m_fail >= MAX_FAIL) begin
            mode      = M_LOCKED;
            lock_left = LOCK_CYCLES - 1;
          end else mode = M_ENTRY;
          digits.delete();
          m_right = 1'b0;
        end
        M_CHANGING: begin
          if (dig && newd.size() < 4) newd.push_back(int'(c));
          else if (c == K_ENTER && newd.size() == 4) begin
            m_pwd = pack(newd);
            mode  = M_CHANGED;
          end else if (c == K_CLEAR) begin
            mode = M_ENTRY;
            digits.delete();
          end
        end
        default: begin
          mode = M_ENTRY;
          digits.delete();
        end
      endcase
    end
  endfunction

  function automatic logic [10:0] model_vec();
    logic [3:0] st;
    case (mode)
      M_ENTRY:    st = 4'(digits.size());
      M_JUDGED:   st = 4'd5;
      M_CHANGING: st = 4'd6;
      M_CHANGED:  st = 4'd7;
      default:    st = 4'd8;
    endcase
    return {st, m_right, (mode == M_CHANGED), (mode == M_JUDGED && m_right), 4'(m_fail)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.state_ctrl, bus.right_flag, bus.changed_flag, bus.unlock, bus.fail_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = v;
    bus.key_code  = c;
    @(posedge clk);
    #1;
    model_step(v, c);
    bus.key_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) cycle(1'b1, code[i*4 +: 4]);
    cycle(1'b1, K_ENTER);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    model_reset();
    #12;
    vectors++;
    if (dut_vec() !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 11'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unlock_default();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'(i + 1));
      vectors++;
      if (bus.state_ctrl !== 4'(i + 1)) begin
        miscompares++;
        $display("FAIL digit_state: got %0d expected %0d", bus.state_ctrl, i + 1);
      end
    end
    cycle(1'b1, K_ENTER);
    vectors++;
    if ({bus.state_ctrl, bus.right_flag, bus.unlock, bus.fail_cnt} !== {4'd5, 1'b1, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL judge_match: got st=%0d right=%b unlock=%b fail=%0d expected st=5 right=1 unlock=1 fail=0",
               bus.state_ctrl, bus.right_flag, bus.unlock, bus.fail_cnt);
    end
    cycle(1'b1, 4'd7);
    vectors++;
    if ({bus.state_ctrl, bus.right_flag, bus.unlock} !== {4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL judge_exit: got st=%0d right=%b unlock=%b expected st=0 right=0 unlock=0",
               bus.state_ctrl, bus.right_flag, bus.unlock);
    end
  endtask

  task automatic test_short_enter();
    cycle(1'b1, 4'd1);
    cycle(1'b1, 4'd2);
    cycle(1'b1, K_ENTER);
    vectors++;
    if (bus.state_ctrl !== 4'd2) begin
      miscompares++;
      $display("FAIL short_enter: got %0d expected 2", bus.state_ctrl);
    end
    cycle(1'b1, K_CLEAR);
    vectors++;
    if (bus.state_ctrl !== 4'd0) begin
      miscompares++;
      $display("FAIL clear_entry: got %0d expected 0", bus.state_ctrl);
    end
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i));
    cycle(1'b1, K_ENTER);
    vectors++;
    if (bus.right_flag !== 1'b1 || dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL fifth_digit: got %h expected %h", dut_vec(), model_vec());
    end
    cycle(1'b1, K_CLEAR);
  endtask

  task automatic test_lockout();
    int dwell;
    for (int r = 0; r < 3; r++) begin
      send(16'h9999);
      vectors++;
      if (bus.fail_cnt !== 4'(r + 1) || bus.right_flag !== 1'b0) begin
        miscompares++;
        $display("FAIL fail_count: got fail=%0d right=%b expected fail=%0d right=0", bus.fail_cnt, bus.right_flag, r + 1);
      end
      cycle(1'b1, 4'd0);
      vectors++;
      if (bus.state_ctrl !== ((r == 2) ? 4'd8 : 4'd0)) begin
        miscompares++;
        $display("FAIL fail_exit: got %0d expected %0d", bus.state_ctrl, (r == 2) ? 8 : 0);
      end
    end
    dwell = 1;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 4'($urandom_range(0, 9)));
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL lock_model: got %h expected %h", dut_vec(), model_vec());
      end
      if (bus.state_ctrl == 4'd8) dwell++;
      else break;
    end
    vectors++;
    if (dwell !== LOCK_CYCLES) begin
      miscompares++;
      $display("FAIL lock_dwell: got %0d expected %0d", dwell, LOCK_CYCLES);
    end
    vectors++;
    if (bus.state_ctrl !== 4'd0 || bus.fail_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL lock_expiry: got st=%0d fail=%0d expected st=0 fail=0", bus.state_ctrl, bus.fail_cnt);
    end
  endtask

  task automatic test_change_clear();
    send(16'h1234);
    cycle(1'b1, K_CHANGE);
    vectors++;
    if (bus.state_ctrl !== 4'd6) begin
      miscompares++;
      $display("FAIL enter_change: got %0d expected 6", bus.state_ctrl);
    end
    cycle(1'b1, 4'd5);
    cycle(1'b1, 4'd6);
    cycle(1'b1, K_CLEAR);
    vectors++;
    if (bus.state_ctrl !== 4'd0) begin
      miscompares++;
      $display("FAIL change_clear: got %0d expected 0", bus.state_ctrl);
    end
    send(16'h1234);
    vectors++;
    if (bus.right_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL pwd_kept: got %b expected 1", bus.right_flag);
    end
    cycle(1'b1, 4'd0);
  endtask

  task automatic test_change_pwd();
    send(16'h1234);
    cycle(1'b1, K_CHANGE);
    send(16'h5678);
    cycle(1'b0, 4'd0);
    vectors++;
    if (bus.state_ctrl !== 4'd7 || bus.changed_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL pwd_res: got st=%0d changed=%b expected st=7 changed=1", bus.state_ctrl, bus.changed_flag);
    end
    cycle(1'b1, 4'd3);
    vectors++;
    if (bus.state_ctrl !== 4'd0 || bus.changed_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL res_exit: got st=%0d changed=%b expected st=0 changed=0", bus.state_ctrl, bus.changed_flag);
    end
    send(16'h5678);
    vectors++;
    if (bus.right_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL new_pwd: got %b expected 1", bus.right_flag);
    end
    cycle(1'b1, 4'd0);
    send(16'h1234);
    vectors++;
    if (bus.right_flag !== 1'b0 || bus.fail_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL old_pwd: got right=%b fail=%0d expected right=0 fail=1", bus.right_flag, bus.fail_cnt);
    end
    cycle(1'b1, 4'd0);
  endtask

  task automatic pulse_reset(input string where);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (dut_vec() !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_%s: got %h expected %h", where, dut_vec(), 11'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    send(16'h1234);
    vectors++;
    if (bus.right_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL default_pwd_%s: got %b expected 1", where, bus.right_flag);
    end
    cycle(1'b1, 4'd0);
  endtask

  task automatic test_reset_mid_op();
    send(16'h5678);
    cycle(1'b1, K_CHANGE);
    cycle(1'b1, 4'd1);
    cycle(1'b1, 4'd2);
    pulse_reset("chs");
    for (int r = 0; r < 3; r++) begin
      send(16'h9999);
      cycle(1'b1, 4'd0);
    end
    cycle(1'b0, 4'd0);
    cycle(1'b0, 4'd0);
    vectors++;
    if (bus.state_ctrl !== 4'd8) begin
      miscompares++;
      $display("FAIL reach_lock: got %0d expected 8", bus.state_ctrl);
    end
    pulse_reset("lock");
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      exp_q.push_back(model_vec());
      exp = exp_q.pop_front();
      vectors++;
      if (dut_vec() !== exp) begin
        miscompares++;
        $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unlock_default();
    test_short_enter();
    test_lockout();
    test_change_clear();
    test_change_pwd();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
